// File: rtl/cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// cacheline_adaptor
//
// Purpose:
//   Memory-side responder for the cache's physical-memory port. One 256-bit
//   line read or write from the cache is turned into a four-beat, 64-bit
//   burst toward main memory. Read beats are reassembled into a full line
//   and the write line is serialized into beats, lowest address first.
//
// Configuration:
//   ADAPTOR_EARLY_RESP_EN (undefined by default)
//     undefined : a registered DONE cycle follows the last beat, and resp_o
//                 is a registered one-cycle pulse (request-to-resp 5 cycles).
//     defined   : DONE is skipped. resp_o is asserted together with the last
//                 beat's resp_i, and line_o merges the live burst_i into the
//                 top slice during that cycle (request-to-resp 4 cycles).
//
// Ports:
//   clk        in   1        clock, all state on rising edge
//   rst        in   1        asynchronous reset, active low
//   address_i  in   32       line address from cache
//   line_i     in   s_line   write line from cache
//   line_o     out  s_line   assembled read line to cache
//   read_i     in   1        line read request, held until resp_o
//   write_i    in   1        line write request, held until resp_o
//   resp_o     out  1        one-cycle completion pulse to cache
//   address_o  out  32       line-aligned burst address
//   burst_i    in   s_burst  read beat from memory
//   burst_o    out  s_burst  write beat to memory
//   read_o     out  1        burst read request
//   write_o    out  1        burst write request
//   resp_i     in   1        beat handshake from memory
// ---------------------------------------------------------------------------
module cacheline_adaptor #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         address_i,
  input  logic [s_line-1:0]   line_i,
  output logic [s_line-1:0]   line_o,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  output logic [31:0]         address_o,
  input  logic [s_burst-1:0]  burst_i,
  output logic [s_burst-1:0]  burst_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
);

  localparam int num_beats = s_line / s_burst;
  localparam int cnt_w     = $clog2(num_beats);
  localparam logic [cnt_w-1:0] last_cnt  = cnt_w'(num_beats - 1);
  // Clears the line-offset bits of the incoming address.
  localparam logic [31:0]      addr_mask = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // State entered after the final beat of a burst.
`ifdef ADAPTOR_EARLY_RESP_EN
  localparam state_t last_next = IDLE;
`else
  localparam state_t last_next = DONE;
`endif

  state_t              r_state;
  logic [cnt_w-1:0]    r_cnt;
  logic [31:0]         r_addr;
  logic [s_line-1:0]   r_wline;
  logic [s_line-1:0]   r_rline;
  logic [s_burst-1:0]  r_burst;
  logic                r_read;
  logic                r_write;
`ifndef ADAPTOR_EARLY_RESP_EN
  logic                r_resp;
`endif

  logic [cnt_w-1:0]    w_cnt_nxt;
  logic                w_last_beat;

  assign w_cnt_nxt   = r_cnt + cnt_w'(1);
  assign w_last_beat = resp_i && (r_cnt == last_cnt);

  // Burst controller: state, beat counter, latched request and all
  // registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= 32'd0;
      r_wline <= '0;
      r_rline <= '0;
      r_burst <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
`ifndef ADAPTOR_EARLY_RESP_EN
      r_resp  <= 1'b0;
`endif
    end else begin
`ifndef ADAPTOR_EARLY_RESP_EN
      r_resp <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          // Write takes priority when both requests are raised together.
          if (write_i) begin
            r_addr  <= address_i & addr_mask;
            r_wline <= line_i;
            r_burst <= line_i[s_burst-1:0];
            r_cnt   <= '0;
            r_write <= 1'b1;
            r_state <= WRITE;
          end else if (read_i) begin
            r_addr  <= address_i & addr_mask;
            r_cnt   <= '0;
            r_read  <= 1'b1;
            r_state <= READ;
          end else begin
            r_state <= IDLE;
          end
        end
        READ: begin
          if (resp_i) begin
            r_rline[r_cnt*s_burst +: s_burst] <= burst_i;
            r_cnt <= w_cnt_nxt;
            if (w_last_beat) begin
              r_read  <= 1'b0;
              r_state <= last_next;
`ifndef ADAPTOR_EARLY_RESP_EN
              r_resp  <= 1'b1;
`endif
            end else begin
              r_state <= READ;
            end
          end else begin
            r_state <= READ;
          end
        end
        WRITE: begin
          if (resp_i) begin
            r_cnt <= w_cnt_nxt;
            if (w_last_beat) begin
              // Last beat stays on burst_o; write_o drop marks it stale.
              r_write <= 1'b0;
              r_state <= last_next;
`ifndef ADAPTOR_EARLY_RESP_EN
              r_resp  <= 1'b1;
`endif
            end else begin
              r_burst <= r_wline[w_cnt_nxt*s_burst +: s_burst];
              r_state <= WRITE;
            end
          end else begin
            r_state <= WRITE;
          end
        end
        DONE: begin
          // Requests are not sampled here; the cache drops them this edge.
          r_state <= IDLE;
        end
        default: begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign address_o = r_addr;
  assign burst_o   = r_burst;
  assign read_o    = r_read;
  assign write_o   = r_write;

`ifdef ADAPTOR_EARLY_RESP_EN
  assign resp_o = w_last_beat && ((r_state == READ) || (r_state == WRITE));
  // During the final read beat the top slice comes straight from memory.
  assign line_o = ((r_state == READ) && (r_cnt == last_cnt))
                ? {burst_i, r_rline[s_line-s_burst-1:0]}
                : r_rline;
`else
  assign resp_o = r_resp;
  assign line_o = r_rline;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// tb_cacheline_adaptor
//
// Directed bench for cacheline_adaptor (default build). Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge. Cycle k is the
// interval after edge k-1, where edge 0 is the first edge that sees a request.
// ---------------------------------------------------------------------------
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] B0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B3 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2 = 64'hA5A5_A5A5_0F0F_0F0F;
  localparam logic [63:0] D3 = 64'h5A5A_5A5A_F0F0_F0F0;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .address_o (address_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [255:0] act,
                             input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs the beat phase of a read, starting in cycle 1 of the burst, and
  // ends in the resp_o cycle with the completion checks done.
  task automatic read_beats(input logic [31:0] exp_addr,
                            input logic [255:0] exp_line,
                            input int npat, input logic [15:0] pat);
    int k;
    k = 0;
    for (int i = 0; i < npat; i++) begin
      check_value("rd_read_o", 256'(read_o), 256'd1);
      check_value("rd_resp_o_low", 256'(resp_o), 256'd0);
      check_value("rd_addr", 256'(address_o), 256'(exp_addr));
      resp_i = pat[i];
      if (pat[i]) begin
        burst_i = exp_line[k*64 +: 64];
        k++;
      end else begin
        burst_i = JUNK;
      end
      tick();
    end
    resp_i  = 1'b0;
    burst_i = JUNK;
    check_value("rd_resp_o", 256'(resp_o), 256'd1);
    check_value("rd_read_o_done", 256'(read_o), 256'd0);
    check_value("rd_line", line_o, exp_line);
  endtask

  // Same as read_beats for a write: checks burst_o beat by beat.
  task automatic write_beats(input logic [31:0] exp_addr,
                             input logic [255:0] line,
                             input int npat, input logic [15:0] pat);
    int k;
    k = 0;
    for (int i = 0; i < npat; i++) begin
      check_value("wr_write_o", 256'(write_o), 256'd1);
      check_value("wr_read_o", 256'(read_o), 256'd0);
      check_value("wr_resp_o_low", 256'(resp_o), 256'd0);
      check_value("wr_addr", 256'(address_o), 256'(exp_addr));
      check_value("wr_burst", 256'(burst_o), 256'(line[k*64 +: 64]));
      resp_i = pat[i];
      if (pat[i]) k++;
      tick();
    end
    resp_i = 1'b0;
    check_value("wr_resp_o", 256'(resp_o), 256'd1);
    check_value("wr_write_o_done", 256'(write_o), 256'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_value({tag, "_resp_o"},  256'(resp_o),  256'd0);
    check_value({tag, "_read_o"},  256'(read_o),  256'd0);
    check_value({tag, "_write_o"}, 256'(write_o), 256'd0);
  endtask

  initial begin
    logic [255:0] rd_line;
    logic [255:0] wr_line;
    rd_line = {B3, B2, B1, B0};
    wr_line = {D3, D2, D1, D0};

    rst = 1'b0; address_i = 32'd0; line_i = 256'd0; read_i = 1'b0;
    write_i = 1'b0; burst_i = 64'd0; resp_i = 1'b0;

    // Reset values.
    tick(); tick();
    check_idle_outputs("rst");
    check_value("rst_addr",  256'(address_o), 256'd0);
    check_value("rst_burst", 256'(burst_o),   256'd0);
    check_value("rst_line",  line_o,          256'd0);
    rst = 1'b1;
    tick();

    // Plain read, no gaps: resp_o in cycle 5, IDLE in cycle 6.
    read_i = 1'b1; address_i = 32'h0000_1234;
    tick();
    read_beats(32'h0000_1220, rd_line, 4, 16'h000F);
    read_i = 1'b0;
    tick();
    check_idle_outputs("rd_after");
    check_value("rd_line_hold", line_o, rd_line);

    // Plain write, resp_i ignored while idle.
    resp_i = 1'b1;
    tick();
    check_idle_outputs("idle_resp_ignored");
    resp_i = 1'b0;
    write_i = 1'b1; address_i = 32'h0000_2040; line_i = wr_line;
    tick();
    write_beats(32'h0000_2040, wr_line, 4, 16'h000F);
    write_i = 1'b0;
    tick();
    check_idle_outputs("wr_after");
    check_value("wr_line_o_kept", line_o, rd_line);

    // Read with gaps 1,0,0,1,1,0,1: read_o for 7 cycles, resp_o in cycle 8.
    read_i = 1'b1; address_i = 32'h8000_001F;
    tick();
    read_beats(32'h8000_0000, {D0, D1, B2, B3}, 7, 16'h0059);
    read_i = 1'b0;
    tick();
    check_idle_outputs("gap_after");

    // Write with gaps: burst_o must hold during idle beats.
    write_i = 1'b1; address_i = 32'h0000_0060; line_i = {B0, D2, B3, D1};
    tick();
    write_beats(32'h0000_0060, {B0, D2, B3, D1}, 6, 16'h002D);
    write_i = 1'b0;
    tick();

    // Simultaneous read and write: write first, then the still-held read.
    read_i = 1'b1; write_i = 1'b1; address_i = 32'hFFFF_FFFF;
    line_i = wr_line;
    tick();
    write_beats(32'hFFFF_FFE0, wr_line, 4, 16'h000F);
    write_i = 1'b0;
    tick();
    check_idle_outputs("both_idle");
    tick();
    read_beats(32'hFFFF_FFE0, {B0, B1, D3, D2}, 4, 16'h000F);
    read_i = 1'b0;
    tick();
    check_idle_outputs("both_after");

    // Reset mid-read after two beats: everything clears, no resp_o.
    read_i = 1'b1; address_i = 32'h0000_4444;
    tick();
    resp_i = 1'b1; burst_i = B0;
    tick();
    burst_i = B1;
    tick();
    resp_i = 1'b0;
    rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    check_value("midrst_addr", 256'(address_o), 256'd0);
    check_value("midrst_line", line_o, 256'd0);
    read_i = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    check_idle_outputs("midrst_rel");
    tick();
    check_value("midrst_no_resp", 256'(resp_o), 256'd0);

    // Follow-up read completes normally.
    read_i = 1'b1; address_i = 32'h0000_4444;
    tick();
    read_beats(32'h0000_4440, rd_line, 4, 16'h000F);
    read_i = 1'b0;
    tick();
    check_idle_outputs("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
